// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide scheduler.
//   md_op_e     - operation codes carried by md_op from decode
//   md_state_e  - scheduler FSM states
//   MULT_LAT_DEF / DIV_LAT_DEF - default busy latencies
//   is_long_op  - true for ops that occupy the unit for a latency window
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu become long ops).
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MD_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational result generator for the multiply/divide unit.
// Produces the 64-bit {hi,lo} value that the scheduler holds as pending
// until the latency window expires.
//   op  - md_op code
//   a,b - operands rs/rt
//   hi,lo - committed HI/LO (accumulator source for madd/msub)
//   res - {hi,lo} result; ops without a result return {hi,lo} unchanged
// Optional feature macro: MD_MADD_EN (adds madd/maddu/msub/msubu).
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] a_s;
  logic signed [63:0] b_s;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;

  // Signed divide with the architectural corner cases: divide by zero
  // returns {dividend, all-ones}, and the single overflowing pair
  // (-2^31 / -1) returns quotient -2^31 with zero remainder.
  function automatic logic [63:0] sdiv(input logic signed [31:0] n,
                                       input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (d == 32'sd0) return {n, 32'hFFFF_FFFF};
    if (n == 32'sh8000_0000 && d == -32'sd1) return {32'h0000_0000, 32'h8000_0000};
    q = n / d;
    r = n % d;
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] n,
                                       input logic [31:0] d);
    if (d == 32'd0) return {n, 32'hFFFF_FFFF};
    return {n % d, n / d};
  endfunction

  assign a_s   = {{32{a[31]}}, a};
  assign b_s   = {{32{b[31]}}, b};
  assign sprod = a_s * b_s;
  assign uprod = {32'd0, a} * {32'd0, b};

  always_comb begin
    res = {hi, lo};
    case (op)
      MULT:  res = sprod;
      MULTU: res = uprod;
      DIV:   res = sdiv(a, b);
      DIVU:  res = udiv(a, b);
`ifdef MD_MADD_EN
      MADD:  res = {hi, lo} + sprod;
      MADDU: res = {hi, lo} + uprod;
      MSUB:  res = {hi, lo} - sprod;
      MSUBU: res = {hi, lo} - uprod;
`endif
      default: res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the EX-stage ALU.
// Accepts an md op when idle, holds its result as pending for a fixed
// latency while busy is high, then commits it to the architectural HI/LO.
// mthi/mtlo write HI/LO on the accepting edge without going busy.
// Ports:
//   clk, rst_n      - clock (rising edge), async active-low reset
//   start, md_op    - op valid in EX and its code
//   a, b            - operands rs/rt, sampled on the accepting edge only
//   busy            - operation in flight (registered)
//   stall_req       - busy, or a long op being presented this cycle
//   hi, lo          - committed HI/LO registers
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu).
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [63:0] pend, pend_n;
  logic [31:0] hi_n, lo_n;
  logic [63:0] calc_res;
  logic        long_op;

  md_calc u_calc (
    .op (md_op),
    .a  (a),
    .b  (b),
    .hi (hi),
    .lo (lo),
    .res(calc_res)
  );

  assign long_op   = is_long_op(md_op);
  assign stall_req = busy | (start & long_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      hi    <= hi_n;
      lo    <= lo_n;
      busy  <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          if (long_op) begin
            pend_n  = calc_res;
            cnt_n   = (md_op == DIV || md_op == DIVU) ? 4'(DIV_LAT) : 4'(MULT_LAT);
            state_n = RUN;
          end else if (md_op == MTHI) begin
            hi_n = a;
          end else if (md_op == MTLO) begin
            lo_n = a;
          end
        end
      end
      RUN: begin
        // Any start presented here is dropped; the hazard unit should
        // never issue one, but operands must not leak in if it does.
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_n    = pend[63:32];
          lo_n    = pend[31:0];
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
